fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined 32-bit MIPS core, directly upstream of the decode stage. Holds the program counter, selects the next PC from sequential, branch and jump targets resolved in decode, and drives the Harvard instruction-memory read address. Contains the IF/ID pipeline register, with hazard-unit stall and redirect-flush control, that feeds InstrD and PCPlus4D to decode.

---
 rtl/mips_pkg.sv | 16 +
 rtl/fetch_stage_if.sv | 28 ++
 rtl/if_id_register.sv | 36 +++
 rtl/fetch_stage.sv | 63 ++++++
 tb/tb_fetch_stage.sv | 135 +++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath width, reset vector, nop encoding
// and the next-PC source encoding driven by decode.
package mips_pkg;

  localparam int          WIDTH     = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

  // bit1 = jump, bit0 = branch taken; 2'b11 resolves to jump
  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: decode/hazard/imem side is the master, fetch stage the slave.
interface fetch_stage_if
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::WIDTH
);
  logic [1:0]       PCSrcD;
  logic [WIDTH-1:0] PCBranchD;
  logic [WIDTH-1:0] PCJumpD;
  logic             StallF;
  logic             StallD;
  logic [WIDTH-1:0] InstrF;
  logic [WIDTH-1:0] PCF;
  logic [WIDTH-1:0] InstrD;
  logic [WIDTH-1:0] PCPlus4D;
  logic             ValidD;
  logic [31:0]      FetchCount;

  modport master (
    output PCSrcD, PCBranchD, PCJumpD, StallF, StallD, InstrF,
    input  PCF, InstrD, PCPlus4D, ValidD, FetchCount
  );

  modport slave (
    input  PCSrcD, PCBranchD, PCJumpD, StallF, StallD, InstrF,
    output PCF, InstrD, PCPlus4D, ValidD, FetchCount
  );
endinterface

// File: rtl/if_id_register.sv
// Generic pipeline register with enable (hold), synchronous flush and valid bit.
// Flushed/reset payload is all-zero, which decodes as a nop.
module if_id_register #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o,
  output logic          valid_o
);

  logic [DW-1:0] data_q;
  logic          valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (en_i) begin
      if (clr_i) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= d_i;
        valid_q <= 1'b1;
      end
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select, IF/ID register
// and a count of PC advances since reset.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int               WIDTH    = mips_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = mips_pkg::RESET_PC[WIDTH-1:0]
) (
  input  logic          CLK,
  input  logic          RST,
  fetch_stage_if.slave  bus
);

  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]   pcplus4_f;
  logic [31:0]        fetch_count_q, fetch_count_d;
  logic               redirect;
  logic [2*WIDTH-1:0] if_id_d, if_id_q;

  assign pcplus4_f = pc_q + WIDTH'(4);

  // A stalled decode stage must not act on its branch/jump yet
  always_comb begin
    redirect = (bus.PCSrcD != PCSRC_SEQ) && !bus.StallD;
    pc_d     = pcplus4_f;
    if (redirect) begin
      if (bus.PCSrcD[1]) pc_d = bus.PCJumpD;
      else               pc_d = bus.PCBranchD;
    end
  end

  assign fetch_count_d = fetch_count_q + 32'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else if (!bus.StallF) begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign if_id_d = {bus.InstrF, pcplus4_f};

  if_id_register #(
    .DW (2*WIDTH)
  ) u_if_id (
    .clk     (CLK),
    .rst     (RST),
    .en_i    (!bus.StallD),
    .clr_i   (redirect),
    .d_i     (if_id_d),
    .q_o     (if_id_q),
    .valid_o (bus.ValidD)
  );

  assign bus.PCF        = pc_q;
  assign bus.InstrD     = if_id_q[2*WIDTH-1:WIDTH];
  assign bus.PCPlus4D   = if_id_q[WIDTH-1:0];
  assign bus.FetchCount = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus async-reset and
// post-reset sequences.
module tb_fetch_stage;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  fetch_stage_if #(.WIDTH(32)) bus ();

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] br;
    logic [31:0] jp;
    logic        sf;
    logic        sd;
    logic [31:0] instr;
    logic [31:0] pcf;
    logic [31:0] instrd;
    logic [31:0] p4d;
    logic        vd;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pcf, input logic [31:0] instrd,
                         input logic [31:0] p4d, input logic vd, input logic [31:0] cnt);
    chk({tag, " PCF"},        bus.PCF,              pcf);
    chk({tag, " InstrD"},     bus.InstrD,           instrd);
    chk({tag, " PCPlus4D"},   bus.PCPlus4D,         p4d);
    chk({tag, " ValidD"},     {31'b0, bus.ValidD},  {31'b0, vd});
    chk({tag, " FetchCount"}, bus.FetchCount,       cnt);
  endtask

  task automatic drive(input logic [1:0] src, input logic [31:0] br, input logic [31:0] jp,
                       input logic sf, input logic sd, input logic [31:0] instr);
    bus.PCSrcD    = src;
    bus.PCBranchD = br;
    bus.PCJumpD   = jp;
    bus.StallF    = sf;
    bus.StallD    = sd;
    bus.InstrF    = instr;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //          src    br            jp            sf    sd    instr         pcf           instrd        p4d           vd    cnt
    vecs[0]  = '{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 32'h2001_0005, 32'h4,        32'h2001_0005, 32'h4,        1'b1, 32'd1};
    vecs[1]  = '{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 32'h1111_1111, 32'h8,        32'h1111_1111, 32'h8,        1'b1, 32'd2};
    vecs[2]  = '{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 32'h2222_2222, 32'hC,        32'h2222_2222, 32'hC,        1'b1, 32'd3};
    vecs[3]  = '{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 32'h3333_3333, 32'h10,       32'h3333_3333, 32'h10,       1'b1, 32'd4};
    // branch taken at PCF=0x10
    vecs[4]  = '{2'b01, 32'h40,       32'h0,        1'b0, 1'b0, 32'h4444_4444, 32'h40,       32'h0,         32'h0,        1'b0, 32'd5};
    vecs[5]  = '{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 32'h5555_5555, 32'h44,       32'h5555_5555, 32'h44,       1'b1, 32'd6};
    // jump and branch together: jump wins
    vecs[6]  = '{2'b11, 32'h40,       32'h100,      1'b0, 1'b0, 32'h6666_6666, 32'h100,      32'h0,         32'h0,        1'b0, 32'd7};
    vecs[7]  = '{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 32'h7777_7777, 32'h104,      32'h7777_7777, 32'h104,      1'b1, 32'd8};
    // full stall with a pending branch: nothing moves
    vecs[8]  = '{2'b01, 32'h40,       32'h0,        1'b1, 1'b1, 32'h8888_8888, 32'h104,      32'h7777_7777, 32'h104,      1'b1, 32'd8};
    vecs[9]  = '{2'b01, 32'h40,       32'h0,        1'b1, 1'b1, 32'h8888_8888, 32'h104,      32'h7777_7777, 32'h104,      1'b1, 32'd8};
    vecs[10] = '{2'b01, 32'h40,       32'h0,        1'b1, 1'b1, 32'h8888_8888, 32'h104,      32'h7777_7777, 32'h104,      1'b1, 32'd8};
    vecs[11] = '{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 32'h9999_9999, 32'h108,      32'h9999_9999, 32'h108,      1'b1, 32'd9};
    // StallD only: PC advances, IF/ID holds
    vecs[12] = '{2'b00, 32'h0,        32'h0,        1'b0, 1'b1, 32'hAAAA_AAAA, 32'h10C,      32'h9999_9999, 32'h108,      1'b1, 32'd10};
    // StallF only: PC and count hold, IF/ID loads
    vecs[13] = '{2'b00, 32'h0,        32'h0,        1'b1, 1'b0, 32'hBBBB_BBBB, 32'h10C,      32'hBBBB_BBBB, 32'h110,      1'b1, 32'd10};
    // jump to top of address space, then wrap
    vecs[14] = '{2'b10, 32'h0,        32'hFFFF_FFFC, 1'b0, 1'b0, 32'hDDDD_DDDD, 32'hFFFF_FFFC, 32'h0,       32'h0,        1'b0, 32'd11};
    vecs[15] = '{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 32'hCCCC_CCCC, 32'h0,        32'hCCCC_CCCC, 32'h0,        1'b1, 32'd12};

    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h2001_0005);
    #2;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].src, vecs[i].br, vecs[i].jp, vecs[i].sf, vecs[i].sd, vecs[i].instr);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].pcf, vecs[i].instrd, vecs[i].p4d, vecs[i].vd, vecs[i].cnt);
      $display("vec%0d: PCF=%h InstrD=%h PCPlus4D=%h ValidD=%0b FetchCount=%0d",
               i, bus.PCF, bus.InstrD, bus.PCPlus4D, bus.ValidD, bus.FetchCount);
    end

    // Jump to 0x20, then stall there with a pending branch, and pulse RST mid-cycle
    drive(2'b10, 32'h0, 32'h20, 1'b0, 1'b0, 32'hEEEE_EEEE);
    step();
    chk_all("jmp20", 32'h20, 32'h0, 32'h0, 1'b0, 32'd13);
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1234_5678);
    step();
    chk_all("seq24", 32'h24, 32'h1234_5678, 32'h24, 1'b1, 32'd14);
    drive(2'b01, 32'h80, 32'h0, 1'b1, 1'b1, 32'hFFFF_0000);
    step();
    chk_all("stall", 32'h24, 32'h1234_5678, 32'h24, 1'b1, 32'd14);
    #2;
    RST = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    $display("async_rst: PCF=%h InstrD=%h ValidD=%0b FetchCount=%0d",
             bus.PCF, bus.InstrD, bus.ValidD, bus.FetchCount);
    #1;
    RST = 1'b0;

    // First edge after reset: capture word at RESET_PC
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h2001_0005);
    step();
    chk_all("post_rst", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 32'd1);
    $display("post_rst: PCF=%h InstrD=%h PCPlus4D=%h ValidD=%0b FetchCount=%0d",
             bus.PCF, bus.InstrD, bus.PCPlus4D, bus.ValidD, bus.FetchCount);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
